// File: rtl/rgb332_tmds_encoder.sv
// RGB332 to DVI/HDMI TMDS encoder.
// Expands each colour by bit replication and encodes it into a 10-bit DC-balanced
// symbol over two pipeline stages. During blanking it sends control tokens, with
// {vs,hs} on the blue channel.
module rgb332_tmds_encoder #(
  parameter logic INVERT_SYNC = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] r,
  input  logic [2:0] g,
  input  logic [1:0] b,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimised 9-bit word; bit 8 = 1 marks the XOR chain.
  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTRL_00;
      2'b01:   t = CTRL_01;
      2'b10:   t = CTRL_10;
      default: t = CTRL_11;
    endcase
    return t;
  endfunction

  logic [7:0]        d_p0      [3];
  logic [8:0]        qm_p1_d   [3];
  logic [8:0]        qm_p1_q   [3];
  logic [3:0]        n1_p1_d   [3];
  logic [3:0]        n1_p1_q   [3];
  logic              blank_p1_d, blank_p1_q;
  logic [1:0]        ctrl0_p1_d, ctrl0_p1_q;
  logic signed [4:0] cnt_d     [3];
  logic signed [4:0] cnt_q     [3];
  logic [9:0]        sym_p2_d  [3];
  logic [9:0]        sym_p2_q  [3];

  // Stage 1: expand RGB332 to 8 bits per channel and minimise transitions.
  always_comb begin
    d_p0[0] = {b, b, b, b};
    d_p0[1] = {g, g, g[2:1]};
    d_p0[2] = {r, r, r[2:1]};
    for (int ch = 0; ch < 3; ch++) begin
      qm_p1_d[ch] = tm_encode(d_p0[ch]);
      n1_p1_d[ch] = popcount8(qm_p1_d[ch][7:0]);
    end
    blank_p1_d = blank;
    ctrl0_p1_d = {vs, hs} ^ {2{INVERT_SYNC}};
  end

  // Stage 2: DC balance against the running disparity, or emit a control token.
  always_comb begin
    logic [8:0]        qm;
    logic [3:0]        n1;
    logic signed [4:0] diff;
    logic signed [4:0] delta;
    qm    = 9'd0;
    n1    = 4'd0;
    diff  = 5'sd0;
    delta = 5'sd0;
    for (int ch = 0; ch < 3; ch++) begin
      qm           = qm_p1_q[ch];
      n1           = n1_p1_q[ch];
      diff         = $signed({n1, 1'b0} - 5'd8);   // N1 - N0
      sym_p2_d[ch] = CTRL_00;
      cnt_d[ch]    = cnt_q[ch];
      if (blank_p1_q) begin
        sym_p2_d[ch] = ctrl_token((ch == 0) ? ctrl0_p1_q : 2'b00);
        cnt_d[ch]    = 5'sd0;
      end else begin
        if ((cnt_q[ch] == 5'sd0) || (n1 == 4'd4)) begin
          sym_p2_d[ch] = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
          delta        = qm[8] ? diff : -diff;
        end else if (((cnt_q[ch] > 5'sd0) && (n1 > 4'd4)) ||
                     ((cnt_q[ch] < 5'sd0) && (n1 < 4'd4))) begin
          sym_p2_d[ch] = {1'b1, qm[8], ~qm[7:0]};
          delta        = (qm[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
          sym_p2_d[ch] = {1'b0, qm[8], qm[7:0]};
          delta        = diff - (qm[8] ? 5'sd0 : 5'sd2);
        end
        // Disparity stays within [-10,+10], so 5-bit signed never wraps.
        cnt_d[ch] = cnt_q[ch] + delta;
      end
    end
  end

  // Pipeline registers; reset leaves stage 1 looking like blanking so the
  // outputs keep sending control token 00 until real data arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < 3; ch++) begin
        qm_p1_q[ch]  <= 9'd0;
        n1_p1_q[ch]  <= 4'd0;
        cnt_q[ch]    <= 5'sd0;
        sym_p2_q[ch] <= CTRL_00;
      end
      blank_p1_q <= 1'b1;
      ctrl0_p1_q <= 2'b00;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        qm_p1_q[ch]  <= qm_p1_d[ch];
        n1_p1_q[ch]  <= n1_p1_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
        sym_p2_q[ch] <= sym_p2_d[ch];
      end
      blank_p1_q <= blank_p1_d;
      ctrl0_p1_q <= ctrl0_p1_d;
    end
  end

  assign tmds_ch0 = sym_p2_q[0];
  assign tmds_ch1 = sym_p2_q[1];
  assign tmds_ch2 = sym_p2_q[2];

endmodule
